// File: rtl/ifu_prefetch_pkg.sv
// Shared constants and state encodings for the instruction prefetch queue.
package ifu_prefetch_pkg;

    localparam logic [31:0] INST_NOP  = 32'h0000_0013;
    localparam logic [31:0] ZeroWord  = 32'h0000_0000;
    localparam logic        RstEnable = 1'b0;

    localparam logic IFU_PF_IDLE  = 1'b0;
    localparam logic IFU_PF_FETCH = 1'b1;

    typedef enum logic {
        StIdle  = IFU_PF_IDLE,
        StFetch = IFU_PF_FETCH
    } ifu_pf_state_e;

endpackage

// File: rtl/ifu_prefetch_if.sv
// Instruction bus: request/grant address phase, in-order rvalid data phase.
interface ifu_prefetch_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);

    logic              ibus_req;
    logic [ADDR_W-1:0] ibus_addr;
    logic              ibus_gnt;
    logic              ibus_rvalid;
    logic [DATA_W-1:0] ibus_rdata;

    modport master (
        output ibus_req,
        output ibus_addr,
        input  ibus_gnt,
        input  ibus_rvalid,
        input  ibus_rdata
    );

    modport slave (
        input  ibus_req,
        input  ibus_addr,
        output ibus_gnt,
        output ibus_rvalid,
        output ibus_rdata
    );

endinterface

// File: rtl/ifu_pf_fifo.sv
// Synchronous register FIFO with flush; head word is read straight from storage flops.
module ifu_pf_fifo
    import ifu_prefetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Next-state: flush wins over push/pop; pointers wrap since DEPTH is a power of two.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) begin
                mem_d[wr_ptr_q] = wdata_i;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop_i) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
        end
    end

    // Storage and pointer registers.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/ifu_prefetch.sv
// Instruction prefetch queue: sequential fetch with credit-limited outstanding requests,
// in-order buffering of returned words, and redirect flush with stale-response discard.
module ifu_prefetch
    import ifu_prefetch_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       DATA_W   = 32,
    parameter int unsigned       DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                jump_flag_i,
    input  logic [ADDR_W-1:0]   jump_addr_i,
    input  logic                halt_i,
    ifu_prefetch_if.master      ibus,
    output logic                inst_valid_o,
    output logic [DATA_W-1:0]   inst_o,
    output logic [ADDR_W-1:0]   inst_addr_o,
    input  logic                inst_ready_i
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    ifu_pf_state_e     state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] resp_pc_q, resp_pc_d;
    logic [CNT_W-1:0]  outstanding_q, outstanding_d;
    logic [CNT_W-1:0]  discard_q, discard_d;

    logic [CNT_W-1:0]         fifo_count;
    logic [ADDR_W+DATA_W-1:0] fifo_rdata;
    logic                     fifo_push;
    logic                     fifo_pop;
    logic                     credit_ok;
    logic                     req;
    logic                     xfer;
    logic [ADDR_W-1:0]        jump_pc;
    logic                     unused_jump_lsb;

    assign jump_pc         = {jump_addr_i[ADDR_W-1:2], 2'b00};
    assign unused_jump_lsb = ^jump_addr_i[1:0];

    // Buffered words plus words still owed by the bus must fit the queue.
    assign credit_ok = ({1'b0, fifo_count} + {1'b0, outstanding_q}) < (CNT_W + 1)'(DEPTH);
    assign req       = (state_q == StFetch) && !halt_i && !jump_flag_i && credit_ok;
    assign xfer      = req && ibus.ibus_gnt;

    assign inst_valid_o = (fifo_count != '0);
    assign fifo_pop     = inst_valid_o && inst_ready_i && !jump_flag_i;

    // Next-state for FSM, PCs and in-flight bookkeeping.
    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;
        fifo_push     = 1'b0;

        unique case (state_q)
            StIdle:  state_d = StFetch;
            StFetch: state_d = StFetch;
            default: state_d = StIdle;
        endcase

        if (jump_flag_i) begin
            // Everything still owed by the bus is stale, including earlier discards.
            fetch_pc_d    = jump_pc;
            resp_pc_d     = jump_pc;
            outstanding_d = outstanding_q - CNT_W'(ibus.ibus_rvalid);
            discard_d     = outstanding_d;
        end else begin
            if (xfer) begin
                fetch_pc_d = fetch_pc_q + ADDR_W'(4);
            end
            outstanding_d = outstanding_q + CNT_W'(xfer) - CNT_W'(ibus.ibus_rvalid);
            if (ibus.ibus_rvalid) begin
                if (discard_q != '0) begin
                    discard_d = discard_q - CNT_W'(1);
                end else begin
                    fifo_push = 1'b1;
                    resp_pc_d = resp_pc_q + ADDR_W'(4);
                end
            end
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state_q       <= StIdle;
            fetch_pc_q    <= {RESET_PC[ADDR_W-1:2], 2'b00};
            resp_pc_q     <= {RESET_PC[ADDR_W-1:2], 2'b00};
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    ifu_pf_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ADDR_W + DATA_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush_i (jump_flag_i),
        .push_i  (fifo_push),
        .wdata_i ({resp_pc_q, ibus.ibus_rdata}),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .count_o (fifo_count)
    );

    assign ibus.ibus_req  = req;
    assign ibus.ibus_addr = fetch_pc_q;

    assign inst_o      = inst_valid_o ? fifo_rdata[DATA_W-1:0] : DATA_W'(INST_NOP);
    assign inst_addr_o = inst_valid_o ? fifo_rdata[ADDR_W+DATA_W-1:DATA_W] : ADDR_W'(ZeroWord);

endmodule

// File: tb/tb_ifu_prefetch.sv
// Directed bench for ifu_prefetch; the bus model returns each word's address as its data.
module tb_ifu_prefetch;
    import ifu_prefetch_pkg::*;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              jump_flag = 1'b0;
    logic [ADDR_W-1:0] jump_addr = '0;
    logic              halt = 1'b0;
    logic              ready = 1'b0;
    logic              gnt_en = 1'b0;
    logic              inst_valid;
    logic [DATA_W-1:0] inst;
    logic [ADDR_W-1:0] inst_addr;

    logic              bus_rvalid = 1'b0;
    logic [DATA_W-1:0] bus_rdata = '0;
    int unsigned       cyc = 0;
    int unsigned       lat = 1;
    int unsigned       grant_cnt = 0;
    logic [ADDR_W-1:0] q_addr [$];
    int unsigned       q_stamp [$];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ifu_prefetch_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) ibus ();

    assign ibus.ibus_gnt    = ibus.ibus_req & gnt_en;
    assign ibus.ibus_rvalid = bus_rvalid;
    assign ibus.ibus_rdata  = bus_rdata;

    ifu_prefetch #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .RESET_PC ('0)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .jump_flag_i  (jump_flag),
        .jump_addr_i  (jump_addr),
        .halt_i       (halt),
        .ibus         (ibus),
        .inst_valid_o (inst_valid),
        .inst_o       (inst),
        .inst_addr_o  (inst_addr),
        .inst_ready_i (ready)
    );

    // Bus model: record transfers and consumed responses mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            q_addr.delete();
            q_stamp.delete();
            grant_cnt = 0;
        end else begin
            if (bus_rvalid) begin
                q_addr.delete(0);
                q_stamp.delete(0);
            end
            if (ibus.ibus_req && ibus.ibus_gnt) begin
                q_addr.push_back(ibus.ibus_addr);
                q_stamp.push_back(cyc);
                grant_cnt = grant_cnt + 1;
            end
        end
    end

    // Bus model: present the oldest response once its latency has elapsed.
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (q_addr.size() > 0 && cyc >= q_stamp[0] + lat) begin
            bus_rvalid = 1'b1;
            bus_rdata  = q_addr[0];
        end else begin
            bus_rvalid = 1'b0;
            bus_rdata  = '0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Leaves the bench in cycle 0 (first cycle with rst released).
    task automatic do_reset(input int unsigned latency, input logic rdy);
        rst       = 1'b0;
        jump_flag = 1'b0;
        jump_addr = '0;
        halt      = 1'b0;
        ready     = rdy;
        gnt_en    = 1'b1;
        lat       = latency;
        repeat (3) tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        ready = 1'b1;
        gnt_en = 1'b1;
        repeat (3) tick();
        n_checks++;
        if (ibus.ibus_req !== 1'b0) begin
            n_fail++; $display("FAIL reset_req: got %b exp 0", ibus.ibus_req);
        end
        n_checks++;
        if (ibus.ibus_addr !== 32'h0) begin
            n_fail++; $display("FAIL reset_addr: got %h exp 00000000", ibus.ibus_addr);
        end
        n_checks++;
        if (inst_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid: got %b exp 0", inst_valid);
        end
        n_checks++;
        if (inst !== 32'h0000_0013) begin
            n_fail++; $display("FAIL reset_inst: got %h exp 00000013", inst);
        end
        n_checks++;
        if (inst_addr !== 32'h0) begin
            n_fail++; $display("FAIL reset_inst_addr: got %h exp 00000000", inst_addr);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (ibus.ibus_req !== 1'b0) begin
            n_fail++; $display("FAIL idle_req: got %b exp 0", ibus.ibus_req);
        end
        tick();
        n_checks++;
        if (ibus.ibus_req !== 1'b1 || ibus.ibus_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL first_req: got req=%b addr=%h exp req=1 addr=00000000",
                     ibus.ibus_req, ibus.ibus_addr);
        end
    endtask

    task automatic test_stream();
        do_reset(1, 1'b1);
        tick();
        tick();
        n_checks++;
        if (inst_valid !== 1'b0) begin
            n_fail++; $display("FAIL stream_c2_valid: got %b exp 0", inst_valid);
        end
        tick();
        for (int k = 0; k < 8; k++) begin
            n_checks++;
            if (inst_valid !== 1'b1 || inst_addr !== 32'(4 * k) || inst !== 32'(4 * k)) begin
                n_fail++;
                $display("FAIL stream_%0d: got v=%b addr=%h inst=%h exp v=1 addr=%h inst=%h",
                         k, inst_valid, inst_addr, inst, 32'(4 * k), 32'(4 * k));
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        int unsigned exp_addr;
        int          got;
        do_reset(1, 1'b0);
        repeat (12) tick();
        n_checks++;
        if (grant_cnt !== 4) begin
            n_fail++; $display("FAIL bp_grants: got %0d exp 4", grant_cnt);
        end
        n_checks++;
        if (ibus.ibus_req !== 1'b0) begin
            n_fail++; $display("FAIL bp_req: got %b exp 0", ibus.ibus_req);
        end
        n_checks++;
        if (inst_valid !== 1'b1 || inst_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL bp_head: got v=%b addr=%h exp v=1 addr=00000000", inst_valid, inst_addr);
        end
        ready    = 1'b1;
        exp_addr = 0;
        got      = 0;
        for (int i = 0; i < 30 && got < 8; i++) begin
            if (inst_valid) begin
                n_checks++;
                if (inst_addr !== exp_addr || inst !== exp_addr) begin
                    n_fail++;
                    $display("FAIL bp_resume_%0d: got addr=%h inst=%h exp %h",
                             got, inst_addr, inst, exp_addr);
                end
                exp_addr = exp_addr + 4;
                got++;
            end
            tick();
        end
        n_checks++;
        if (got !== 8) begin
            n_fail++; $display("FAIL bp_resume_count: got %0d exp 8", got);
        end
    endtask

    task automatic test_jump_flush();
        int unsigned exp_addr;
        int          got;
        do_reset(4, 1'b1);
        repeat (3) tick();
        tick();
        gnt_en    = 1'b0;
        jump_flag = 1'b1;
        jump_addr = 32'h0000_0100;
        #1;
        n_checks++;
        if (ibus.ibus_req !== 1'b0) begin
            n_fail++; $display("FAIL jmp_flush_req: got %b exp 0", ibus.ibus_req);
        end
        tick();
        jump_flag = 1'b0;
        gnt_en    = 1'b1;
        #1;
        n_checks++;
        if (inst_valid !== 1'b0 || ibus.ibus_req !== 1'b1 || ibus.ibus_addr !== 32'h100) begin
            n_fail++;
            $display("FAIL jmp_restart: got v=%b req=%b addr=%h exp v=0 req=1 addr=00000100",
                     inst_valid, ibus.ibus_req, ibus.ibus_addr);
        end
        exp_addr = 32'h100;
        got      = 0;
        for (int i = 0; i < 30 && got < 2; i++) begin
            if (inst_valid) begin
                n_checks++;
                if (inst_addr !== exp_addr || inst !== exp_addr) begin
                    n_fail++;
                    $display("FAIL jmp_item_%0d: got addr=%h inst=%h exp %h",
                             got, inst_addr, inst, exp_addr);
                end
                exp_addr = exp_addr + 4;
                got++;
            end
            tick();
        end
        n_checks++;
        if (got !== 2) begin
            n_fail++; $display("FAIL jmp_item_count: got %0d exp 2", got);
        end
    endtask

    task automatic test_jump_rvalid();
        int got;
        do_reset(1, 1'b1);
        tick();
        tick();
        jump_flag = 1'b1;
        jump_addr = 32'h0000_0202;
        #1;
        n_checks++;
        if (ibus.ibus_req !== 1'b0) begin
            n_fail++; $display("FAIL jrv_req: got %b exp 0", ibus.ibus_req);
        end
        tick();
        jump_flag = 1'b0;
        #1;
        n_checks++;
        if (inst_valid !== 1'b0 || ibus.ibus_req !== 1'b1 || ibus.ibus_addr !== 32'h200) begin
            n_fail++;
            $display("FAIL jrv_restart: got v=%b req=%b addr=%h exp v=0 req=1 addr=00000200",
                     inst_valid, ibus.ibus_req, ibus.ibus_addr);
        end
        got = 0;
        for (int i = 0; i < 20 && got < 1; i++) begin
            if (inst_valid) begin
                n_checks++;
                if (inst_addr !== 32'h200 || inst !== 32'h200) begin
                    n_fail++;
                    $display("FAIL jrv_item: got addr=%h inst=%h exp 00000200", inst_addr, inst);
                end
                got++;
            end
            tick();
        end
        n_checks++;
        if (got !== 1) begin
            n_fail++; $display("FAIL jrv_item_count: got %0d exp 1", got);
        end
    endtask

    task automatic test_wrap();
        logic [ADDR_W-1:0] exp_addr;
        int                got;
        do_reset(1, 1'b1);
        tick();
        jump_flag = 1'b1;
        jump_addr = 32'hFFFF_FFFC;
        tick();
        jump_flag = 1'b0;
        #1;
        n_checks++;
        if (ibus.ibus_req !== 1'b1 || ibus.ibus_addr !== 32'hFFFF_FFFC) begin
            n_fail++;
            $display("FAIL wrap_first: got req=%b addr=%h exp req=1 addr=fffffffc",
                     ibus.ibus_req, ibus.ibus_addr);
        end
        tick();
        n_checks++;
        if (ibus.ibus_addr !== 32'h0) begin
            n_fail++; $display("FAIL wrap_next: got %h exp 00000000", ibus.ibus_addr);
        end
        exp_addr = 32'hFFFF_FFFC;
        got      = 0;
        for (int i = 0; i < 20 && got < 2; i++) begin
            if (inst_valid) begin
                n_checks++;
                if (inst_addr !== exp_addr || inst !== exp_addr) begin
                    n_fail++;
                    $display("FAIL wrap_item_%0d: got addr=%h inst=%h exp %h",
                             got, inst_addr, inst, exp_addr);
                end
                exp_addr = exp_addr + 32'd4;
                got++;
            end
            tick();
        end
        n_checks++;
        if (got !== 2) begin
            n_fail++; $display("FAIL wrap_item_count: got %0d exp 2", got);
        end
    endtask

    task automatic test_halt();
        int unsigned exp_addr;
        int          got;
        do_reset(1, 1'b0);
        tick();
        tick();
        tick();
        gnt_en = 1'b0;
        #1;
        n_checks++;
        if (ibus.ibus_req !== 1'b1 || ibus.ibus_addr !== 32'h8) begin
            n_fail++;
            $display("FAIL halt_pending: got req=%b addr=%h exp req=1 addr=00000008",
                     ibus.ibus_req, ibus.ibus_addr);
        end
        tick();
        n_checks++;
        if (ibus.ibus_req !== 1'b1 || ibus.ibus_addr !== 32'h8) begin
            n_fail++;
            $display("FAIL halt_stable: got req=%b addr=%h exp req=1 addr=00000008",
                     ibus.ibus_req, ibus.ibus_addr);
        end
        halt = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_checks++;
            if (ibus.ibus_req !== 1'b0) begin
                n_fail++; $display("FAIL halt_req_%0d: got %b exp 0", i, ibus.ibus_req);
            end
            tick();
        end
        n_checks++;
        if (grant_cnt !== 2 || inst_valid !== 1'b1 || inst_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL halt_hold: got grants=%0d v=%b addr=%h exp grants=2 v=1 addr=00000000",
                     grant_cnt, inst_valid, inst_addr);
        end
        halt   = 1'b0;
        gnt_en = 1'b1;
        #1;
        n_checks++;
        if (ibus.ibus_req !== 1'b1 || ibus.ibus_addr !== 32'h8) begin
            n_fail++;
            $display("FAIL halt_release: got req=%b addr=%h exp req=1 addr=00000008",
                     ibus.ibus_req, ibus.ibus_addr);
        end
        ready    = 1'b1;
        exp_addr = 0;
        got      = 0;
        for (int i = 0; i < 20 && got < 3; i++) begin
            if (inst_valid) begin
                n_checks++;
                if (inst_addr !== exp_addr || inst !== exp_addr) begin
                    n_fail++;
                    $display("FAIL halt_item_%0d: got addr=%h inst=%h exp %h",
                             got, inst_addr, inst, exp_addr);
                end
                exp_addr = exp_addr + 4;
                got++;
            end
            tick();
        end
        n_checks++;
        if (got !== 3) begin
            n_fail++; $display("FAIL halt_item_count: got %0d exp 3", got);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_jump_flush();
        test_jump_rvalid();
        test_wrap();
        test_halt();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ifu_prefetch.md
# ifu_prefetch

Parametrised instruction-prefetch queue for the core front end: issues sequential fetches on a request/grant/response instruction bus with up to DEPTH requests in flight, buffers returned words with their addresses, and presents them in order to the if_id stage via valid/ready. On a redirect (jump_flag_i) it flushes buffered words, drops responses still in flight, and restarts fetching at the new PC. It replaces the combinational single-word PC→ROM path, so fetch latency from slow memories is hidden.

## Interface
- ADDR_W, 32, instruction address width
- DATA_W, 32, instruction word width
- DEPTH, 4, queue entries and max outstanding requests (power of 2, ≥2)
- RESET_PC, 0, first fetch address after reset
- clk  in  1  core clock
- rst  in  1  reset; one clock; reset is synchronous and active-low
- jump_flag_i  in  1  redirect/flush request
- jump_addr_i  in  ADDR_W  redirect target (bits [1:0] ignored, treated as 0)
- halt_i  in  1  stop issuing new requests (jtag halt); in-flight responses still accepted
- ibus_req_o  out  1  fetch request
- ibus_addr_o  out  ADDR_W  fetch address, word aligned
- ibus_gnt_i  in  1  request accepted this cycle
- ibus_rvalid_i  in  1  response valid (in request order, ≥1 cycle after gnt)
- ibus_rdata_i  in  DATA_W  response data
- inst_valid_o  out  1  queue head valid
- inst_o  out  DATA_W  head instruction; INST_NOP (0x00000013) when empty
- inst_addr_o  out  ADDR_W  head address; 0 when empty
- inst_ready_i  in  1  consumer takes head this cycle

## Operation
- State machine: IDLE → FETCH. Reset enters IDLE; IDLE lasts exactly one cycle with ibus_req_o=0, then FETCH.
- FETCH: ibus_req_o=1 when !halt_i && !jump_flag_i && (count + outstanding) < DEPTH. Request transfers on req && gnt; then fetch PC += 4 (mod 2^ADDR_W), outstanding += 1. ibus_addr_o = fetch PC, stable while req && !gnt.
- Response: ibus_rvalid_i decrements outstanding. If discard > 0, discard decrements and data is dropped; else {addr, data} is pushed. Push address tracked by a separate response PC incremented per kept push.
- Pop on inst_valid_o && inst_ready_i. Push and pop in the same cycle allowed at any occupancy; credit rule guarantees push never overflows.
- Flush (jump_flag_i=1): queue emptied; discard ← outstanding − (rvalid this cycle ? 1 : 0) + ... i.e. all responses not yet returned are discarded; an rvalid in the flush cycle is dropped; pop in the flush cycle ignored. Fetch PC and response PC ← {jump_addr_i[ADDR_W-1:2],2'b00}. No request in flush cycle; requests resume next cycle.
- Flush while discard > 0: discard accumulates (outstanding already includes it); value never exceeds DEPTH.
- halt_i mid-stream: a request already asserted but not granted is withdrawn next cycle; queue contents retained.
- Reset mid-operation: all counters, queue, state cleared; any later rvalid for pre-reset requests is a bus protocol violation (bus is reset together).

## Timing
- Reset values: ibus_req_o=0, ibus_addr_o=RESET_PC, inst_valid_o=0, inst_o=INST_NOP, inst_addr_o=0; count, outstanding, discard = 0; state IDLE.
- First request: cycle 1 after rst deasserts.
- Fetch latency: gnt at cycle t, rvalid earliest t+1, inst_valid_o at t+2 (registered queue, no bypass).
- Zero-wait bus with inst_ready_i=1: one instruction per cycle sustained.
- Redirect latency: jump_flag_i at t, new request at t+1, target instruction valid at t+3 earliest.
- Outputs inst_* driven from queue head registers, no combinational path from ibus_* or jump_flag_i.

## Structure
- INST_NOP, ZeroWord, RstEnable already in the shared defines header; add IFU_PF_IDLE / IFU_PF_FETCH state encodings there.
- One sub-module: ifu_pf_fifo (synchronous DEPTH×(ADDR_W+DATA_W) FIFO with flush, push, pop, count). Counters and FSM stay in ifu_prefetch.

## Test plan
- Reset then zero-wait bus returning addr as data, ready=1 → requests 0x0,0x4,0x8…; inst_addr_o 0x0 at cycle 3, then +4 every cycle.
- ready=0 for 10 cycles, DEPTH=4 → exactly 4 grants, req drops, inst_valid_o=1 holding addr 0x0; ready=1 resumes without loss.
- Bus with 3-cycle response delay, 3 outstanding, jump to 0x100 → 3 stale responses dropped, next inst_addr_o=0x100.
- Jump to 0x202 coincident with rvalid → that word dropped, fetch address 0x200.
- Fetch PC 0xFFFFFFFC → next request address 0x00000000.
- halt_i=1 for 5 cycles with gnt held low → req withdrawn, no new grants; queue contents unchanged on release.
